// File: rtl/adrv9001_pkg.sv
// Shared definitions for the ADRV9001 TDD scheduling logic.
//   tdd_state_e : scheduler FSM states
//   CH_*        : bit positions of each channel in the ch_en vector
package adrv9001_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun
  } tdd_state_e;

  localparam int unsigned CH_RX1 = 0;
  localparam int unsigned CH_RX2 = 1;
  localparam int unsigned CH_TX1 = 2;
  localparam int unsigned CH_TX2 = 3;

endpackage

// File: rtl/adrv9001_tdd_window.sv
// Per-channel on/off window compare with a registered enable output.
//   clk, rst : clock, asynchronous active-high reset
//   on_cnt   : counter value at which the window opens
//   off_cnt  : counter value at which the window closes
//   cnt      : current frame counter
//   run      : qualifies the window; low forces the enable low on the next edge
//   en       : registered enable, one cycle behind the qualifying counter value
module adrv9001_tdd_window
  import adrv9001_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] on_cnt,
  input  logic [CNT_WIDTH-1:0] off_cnt,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 run,
  output logic                 en
);

  logic hit;

  // on > off describes a window that wraps across the frame boundary.
  always_comb begin
    hit = 1'b0;
    if (on_cnt < off_cnt) begin
      hit = (cnt >= on_cnt) && (cnt < off_cnt);
    end else if (on_cnt > off_cnt) begin
      hit = (cnt >= on_cnt) || (cnt < off_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en <= 1'b0;
    end else begin
      en <= run && hit;
    end
  end

endmodule

// File: rtl/adrv9001_tdd_sched.sv
// Frame-based TDD scheduler for the ADRV9001 rx1/rx2/tx1/tx2 channels.
//   clk, rst   : s_axi_aclk, asynchronous active-high reset
//   start      : pulse, latch configuration and begin the schedule
//   stop       : pulse, stop gracefully at the end of the current frame
//   abort      : immediate stop, enables dropped on the next edge
//   sync_mode  : wait for a sync_in rising edge before frame 0
//   sync_in    : external frame sync, synchronous to clk
//   frame_len  : last counter value of a frame (period = frame_len + 1)
//   num_frames : frames to run, 0 = continuous
//   on_cnt     : packed per-channel window open values
//   off_cnt    : packed per-channel window close values
//   ch_en      : registered per-channel TDD enables {tx2,tx1,rx2,rx1}
//   frame_strb : registered pulse for counter == 0 in RUN
//   frame_cnt  : frames completed since the last accepted start
//   busy       : high while ARMED or RUN
//   done       : pulse on the RUN -> IDLE transition at a frame wrap
module adrv9001_tdd_sched
  import adrv9001_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned FRM_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        abort,
  input  logic                        sync_mode,
  input  logic                        sync_in,
  input  logic [CNT_WIDTH-1:0]        frame_len,
  input  logic [FRM_WIDTH-1:0]        num_frames,
  input  logic [NUM_CH*CNT_WIDTH-1:0] on_cnt,
  input  logic [NUM_CH*CNT_WIDTH-1:0] off_cnt,
  output logic [NUM_CH-1:0]           ch_en,
  output logic                        frame_strb,
  output logic [FRM_WIDTH-1:0]        frame_cnt,
  output logic                        busy,
  output logic                        done
);

  tdd_state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [FRM_WIDTH-1:0]        fcnt_q, fcnt_d;
  logic                        pend_q, pend_d;
  logic                        sync_q;
  logic                        strb_q, strb_d;
  logic                        done_q, done_d;
  logic                        accept;
  logic                        run_en;
  logic                        wrap;
  logic                        last;

  // Shadow configuration, only loaded by an accepted start.
  logic [CNT_WIDTH-1:0]        len_q;
  logic [FRM_WIDTH-1:0]        nfr_q;
  logic [NUM_CH*CNT_WIDTH-1:0] on_q;
  logic [NUM_CH*CNT_WIDTH-1:0] off_q;

  assign wrap   = (cnt_q == len_q);
  assign last   = (nfr_q != '0) && ((fcnt_q + FRM_WIDTH'(1)) == nfr_q);
  // Gating with abort makes the enables drop on the same edge the FSM leaves RUN.
  assign run_en = (state_q == StRun) && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    strb_d  = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    if (abort) begin
      state_d = StIdle;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            accept  = 1'b1;
            cnt_d   = '0;
            fcnt_d  = '0;
            pend_d  = 1'b0;
            state_d = sync_mode ? StArmed : StRun;
          end
        end
        StArmed: begin
          if (stop) begin
            state_d = StIdle;
          end else if (sync_in && !sync_q) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        StRun: begin
          strb_d = (cnt_q == '0);
          if (stop) begin
            pend_d = 1'b1;
          end
          if (wrap) begin
            cnt_d = '0;
            if (fcnt_q != '1) begin
              fcnt_d = fcnt_q + FRM_WIDTH'(1);
            end
            // A stop arriving on the wrap cycle still ends the current frame.
            if (last || pend_q || stop) begin
              state_d = StIdle;
              done_d  = 1'b1;
              pend_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      sync_q  <= 1'b0;
      strb_q  <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      nfr_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      sync_q  <= sync_in;
      strb_q  <= strb_d;
      done_q  <= done_d;
      if (accept) begin
        len_q <= frame_len;
        nfr_q <= num_frames;
        on_q  <= on_cnt;
        off_q <= off_cnt;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_win
    adrv9001_tdd_window #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_win (
      .clk    (clk),
      .rst    (rst),
      .on_cnt (on_q[i*CNT_WIDTH +: CNT_WIDTH]),
      .off_cnt(off_q[i*CNT_WIDTH +: CNT_WIDTH]),
      .cnt    (cnt_q),
      .run    (run_en),
      .en     (ch_en[i])
    );
  end

  assign frame_strb = strb_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_adrv9001_tdd_sched.sv
// Self-checking bench for adrv9001_tdd_sched: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_adrv9001_tdd_sched;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CW     = 32;
  localparam int unsigned FW     = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0, stop = 1'b0, abort = 1'b0;
  logic                   sync_mode = 1'b0, sync_in = 1'b0;
  logic [CW-1:0]          frame_len = '0;
  logic [FW-1:0]          num_frames = '0;
  logic [NUM_CH*CW-1:0]   on_cnt = '0, off_cnt = '0;
  logic [NUM_CH-1:0]      ch_en;
  logic                   frame_strb, busy, done;
  logic [FW-1:0]          frame_cnt;

  adrv9001_tdd_sched #(
    .NUM_CH   (NUM_CH),
    .CNT_WIDTH(CW),
    .FRM_WIDTH(FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .abort     (abort),
    .sync_mode (sync_mode),
    .sync_in   (sync_in),
    .frame_len (frame_len),
    .num_frames(num_frames),
    .on_cnt    (on_cnt),
    .off_cnt   (off_cnt),
    .ch_en     (ch_en),
    .frame_strb(frame_strb),
    .frame_cnt (frame_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 waiting for sync, 2 running.
  // While running, m_t counts cycles since frame 0 began; the counter value
  // and completed-frame count are derived from it arithmetically.
  int          m_st;
  longint      m_t, m_p;
  longint      m_nf;
  longint      m_on[NUM_CH], m_off[NUM_CH];
  bit          m_pend, m_sprev;
  bit [3:0]    e_ch;
  bit          e_strb, e_done, e_busy;
  longint      e_fcnt;

  function automatic bit in_win(longint on, longint off, longint c);
    if (on < off) return (c >= on) && (c < off);
    if (on > off) return (c >= on) || (c < off);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_p = 1; m_nf = 0; m_pend = 0; m_sprev = 0;
    e_ch = '0; e_strb = 0; e_done = 0; e_busy = 0; e_fcnt = 0;
  endtask

  task automatic model_step();
    longint c;
    longint frames;
    c = m_t % m_p;
    e_ch = '0; e_strb = 0; e_done = 0;
    if (abort) begin
      m_st = 0; m_pend = 0;
    end else if (m_st == 0) begin
      if (start && !stop) begin
        m_p = longint'(frame_len) + 1;
        m_nf = longint'(num_frames);
        for (int i = 0; i < NUM_CH; i++) begin
          m_on[i]  = longint'(on_cnt[i*CW +: CW]);
          m_off[i] = longint'(off_cnt[i*CW +: CW]);
        end
        m_t = 0; m_pend = 0; e_fcnt = 0;
        m_st = sync_mode ? 1 : 2;
      end
    end else if (m_st == 1) begin
      if (stop) m_st = 0;
      else if (sync_in && !m_sprev) begin
        m_st = 2; m_t = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) e_ch[i] = in_win(m_on[i], m_off[i], c);
      e_strb = (c == 0);
      if (stop) m_pend = 1;
      if (c == m_p - 1) begin
        frames = m_t / m_p + 1;
        e_fcnt = (frames > 65535) ? 65535 : frames;
        if ((m_nf != 0 && frames == m_nf) || m_pend) begin
          m_st = 0; e_done = 1; m_pend = 0;
        end
      end
      m_t++;
    end
    m_sprev = sync_in;
    e_busy = (m_st != 0);
  endtask

  task automatic check_outs();
    check_eq("ch_en", 64'(ch_en), 64'(e_ch));
    check_eq("frame_strb", 64'(frame_strb), 64'(e_strb));
    check_eq("done", 64'(done), 64'(e_done));
    check_eq("frame_cnt", 64'(frame_cnt), 64'(e_fcnt));
    check_eq("busy", 64'(busy), 64'(e_busy));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    #1 rst = 1'b0;
  endtask

  task automatic set_ch(input int i, input int on, input int off);
    on_cnt[i*CW +: CW]  = CW'(on);
    off_cnt[i*CW +: CW] = CW'(off);
  endtask

  int done_at, dones;
  int ones[NUM_CH];

  initial begin
    model_reset();
    #12;
    check_outs();
    @(negedge clk) rst = 1'b0;

    // Counted run: 2 frames of 10 cycles, ch0 window [2,5).
    frame_len = 9; num_frames = 2; set_ch(0, 2, 5);
    start = 1; cyc(); start = 0;
    done_at = -1; ones[0] = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      ones[0] += int'(ch_en[0]);
      if (done && done_at < 0) done_at = k;
    end
    check_eq("t1_done_at", 64'(done_at), 64'd20);
    check_eq("t1_ch0_ones", 64'(ones[0]), 64'd6);
    check_eq("t1_frame_cnt", 64'(frame_cnt), 64'd2);

    // Continuous: wrapped, empty and out-of-range windows, then stop at c=3 of frame 5.
    num_frames = 0; set_ch(0, 0, 0); set_ch(1, 8, 2); set_ch(2, 4, 4); set_ch(3, 12, 15);
    start = 1; cyc(); start = 0;
    for (int i = 0; i < NUM_CH; i++) ones[i] = 0;
    for (int k = 1; k <= 50; k++) begin
      cyc();
      for (int i = 0; i < NUM_CH; i++) ones[i] += int'(ch_en[i]);
    end
    check_eq("t2_ch1_ones", 64'(ones[1]), 64'd20);
    check_eq("t3_ch2_ones", 64'(ones[2]), 64'd0);
    check_eq("t3_ch3_ones", 64'(ones[3]), 64'd0);
    repeat (3) cyc();
    stop = 1; cyc(); stop = 0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      dones += int'(done);
    end
    check_eq("t5_dones", 64'(dones), 64'd1);
    check_eq("t5_frame_cnt", 64'(frame_cnt), 64'd6);
    check_eq("t5_busy", 64'(busy), 64'd0);

    // Sync mode: held in ARMED until sync_in rises.
    frame_len = 3; set_ch(0, 0, 2); sync_mode = 1; sync_in = 0;
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    check_eq("t4_busy_armed", 64'(busy), 64'd1);
    check_eq("t4_ch_en_armed", 64'(ch_en), 64'd0);
    sync_in = 1; cyc();
    cyc();
    check_eq("t4_strb", 64'(frame_strb), 64'd1);
    abort = 1; cyc(); abort = 0;
    sync_mode = 0; sync_in = 0;

    // Abort and async reset with ch_en = 0011.
    frame_len = 9; set_ch(0, 1, 6); set_ch(1, 2, 5); set_ch(2, 0, 0); set_ch(3, 0, 0);
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
    check_eq("t6_pre_abort", 64'(ch_en), 64'h3);
    abort = 1; cyc(); abort = 0;
    check_eq("t6_abort_ch_en", 64'(ch_en), 64'd0);
    check_eq("t6_abort_done", 64'(done), 64'd0);
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
    check_eq("t6_pre_rst", 64'(ch_en), 64'h3);
    mid_reset();
    num_frames = 1;
    start = 1; cyc(); start = 0;
    check_eq("t6_restart_fcnt", 64'(frame_cnt), 64'd0);
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done && done_at < 0) done_at = k;
    end
    check_eq("t6_restart_done_at", 64'(done_at), 64'd10);
    check_eq("t6_restart_fcnt_end", 64'(frame_cnt), 64'd1);

    // Randomized traffic; config inputs keep changing to show only start latches them.
    for (int k = 0; k < 4000; k++) begin
      start      = ($urandom_range(5) == 0);
      stop       = ($urandom_range(24) == 0);
      abort      = ($urandom_range(49) == 0);
      sync_mode  = ($urandom_range(2) == 0);
      if ($urandom_range(2) == 0) sync_in = ~sync_in;
      frame_len  = CW'($urandom_range(7));
      num_frames = FW'($urandom_range(3));
      for (int i = 0; i < NUM_CH; i++) set_ch(i, $urandom_range(11), $urandom_range(11));
      cyc();
      if ($urandom_range(299) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
